risc_v_mem_ctrl: RTL and testbench

RISC_V_MEM_CTRL -- requirements
Module: risc_v_mem_ctrl

---
 rtl/risc_v_mem_ctrl_if.sv | 35 +++
 rtl/risc_v_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_risc_v_mem_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/risc_v_mem_ctrl_if.sv
// Core-side request/response bus and byte-memory port of the load/store controller.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle completion pulse.
interface risc_v_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_addr, mem_wdata
  );

  modport mem (
    input  mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/risc_v_mem_ctrl.sv
// Byte-serial load/store controller: splits byte/half/word accesses into one memory
// byte per cycle, assembles and sign/zero-extends loads, rejects misaligned requests.
module risc_v_mem_ctrl #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  risc_v_mem_ctrl_if.slave        bus,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [1:0]            cnt;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic [31:0]           rdata_q;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [7:0]            wdata_hold_q;

  logic                  req_err;
  logic [1:0]            last_cnt;
  logic [4:0]            byte_sel;
  logic [31:0]           data_next;
  logic [31:0]           load_ext;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [7:0]            mem_wdata_c;
  logic                  in_access;

  always_comb begin
    state_next = state;
    req_err    = (bus.req_size == 2'b11)
              || (bus.req_size == 2'b01 && bus.req_addr[0])
              || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    last_cnt   = (size_q == 2'b10) ? 2'd3 : (size_q == 2'b01) ? 2'd1 : 2'd0;
    byte_sel   = {cnt, 3'b000};
    in_access  = (state == ACCESS);
    data_next  = data_q;
    data_next[byte_sel +: 8] = bus.mem_rdata;
    // Extension must see the byte arriving this cycle, hence data_next.
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, data_next[7:0]}
                                : {{24{data_next[7]}}, data_next[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, data_next[15:0]}
                                : {{16{data_next[15]}}, data_next[15:0]};
      default: load_ext = data_next;
    endcase
    mem_addr_c  = in_access ? addr_q + ADDR_WIDTH'(cnt) : addr_hold_q;
    mem_wdata_c = in_access ? wdata_q[byte_sel +: 8] : wdata_hold_q;
    case (state)
      IDLE:    if (bus.req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  if (cnt == last_cnt) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      data_q       <= 32'h0;
      rdata_q      <= 32'h0;
      addr_hold_q  <= '0;
      wdata_hold_q <= 8'h00;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= req_err;
            cnt     <= 2'd0;
            data_q  <= 32'h0;
            if (req_err) rdata_q <= 32'h0;
          end
        end
        ACCESS: begin
          addr_hold_q  <= mem_addr_c;
          wdata_hold_q <= mem_wdata_c;
          if (!write_q) data_q <= data_next;
          if (cnt == last_cnt) begin
            cnt     <= 2'd0;
            rdata_q <= write_q ? 32'h0 : load_ext;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating mem_write with rst keeps an aborting reset from committing the in-flight byte.
  assign bus.mem_write  = in_access && write_q && !rst;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && err_q;
  assign bus.resp_rdata = rdata_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_risc_v_mem_ctrl.sv
// Directed bench for risc_v_mem_ctrl: vector table of requests with hand-computed
// results, plus mid-access reset and back-to-back throughput sequences.
module tb_risc_v_mem_ctrl;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clear = 1'b1;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  risc_v_mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  risc_v_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  logic [7:0] mem [32];
  int write_cnt;
  int resp_cnt;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      write_cnt <= 0;
      resp_cnt  <= 0;
    end else begin
      if (bus.mem_write) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        write_cnt <= write_cnt + 1;
      end
      if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, output int lat, output logic [31:0] rdata,
                        output logic err);
    @(negedge clk);
    check("ready_before_req", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = v.wr;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat   = 0;
    rdata = 32'h0;
    err   = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat   = k;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          w0;
    int          r0;
    int          ndiff;
    int          exp_writes;
    logic [7:0]  snap [32];
    int          accepts;
    int          acc_idx[4];
    int          viol;
    int          resp_in_loop;

    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = 32'h0;

    //            wr    size   uns   addr   wdata          lat rdata          err
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 5'd4,  32'hA1B2C3D4, 5, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 5'd4,  32'h0,        5, 32'hA1B2C3D4, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 5'd9,  32'hDEAD0080, 2, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 5'd9,  32'h0,        2, 32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 5'd9,  32'h0,        2, 32'h00000080, 1'b0};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 5'd30, 32'h7777F234, 3, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 5'd30, 32'h0,        3, 32'hFFFFF234, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 5'd30, 32'h0,        3, 32'h0000F234, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 5'd3,  32'h0000BEEF, 1, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 5'd2,  32'h0,        1, 32'h00000000, 1'b1};
    vecs[10] = '{1'b1, 2'd3, 1'b0, 5'd0,  32'hFFFFFFFF, 1, 32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 5'd6,  32'h0,        3, 32'hFFFFA1B2, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 5'd5,  32'h0,        2, 32'hFFFFFFC3, 1'b0};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 5'd10, 32'h0000005A, 2, 32'h00000000, 1'b0};
    vecs[14] = '{1'b0, 2'd1, 1'b1, 5'd4,  32'h0,        3, 32'h0000C3D4, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    mem_clear = 1'b0;

    check("reset_req_ready",  {31'b0, bus.req_ready},  32'd1);
    check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("reset_resp_err",   {31'b0, bus.resp_err},   32'd0);
    check("reset_resp_rdata", bus.resp_rdata,          32'd0);
    check("reset_mem_write",  {31'b0, bus.mem_write},  32'd0);
    check("reset_mem_addr",   {27'b0, bus.mem_addr},   32'd0);
    check("reset_mem_wdata",  {24'b0, bus.mem_wdata},  32'd0);
    check("reset_fsm_state",  {30'b0, fsm_state},      32'd0);

    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < 32; j++) snap[j] = mem[j];
      w0 = write_cnt;
      exp_q.push_back(vecs[i].rdata);
      do_req(vecs[i], lat, rdata, err);
      @(negedge clk);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_rdata", i), rdata, exp_q.pop_front());
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      exp_writes = (vecs[i].wr && !vecs[i].err) ? (1 << vecs[i].size) : 0;
      check($sformatf("v%0d_write_pulses", i), write_cnt - w0, exp_writes);
      if (vecs[i].err) begin
        ndiff = 0;
        for (int j = 0; j < 32; j++) if (mem[j] !== snap[j]) ndiff++;
        check($sformatf("v%0d_mem_unchanged", i), ndiff, 0);
      end
    end

    check("mem4",  {24'b0, mem[4]},  32'hD4);
    check("mem5",  {24'b0, mem[5]},  32'hC3);
    check("mem6",  {24'b0, mem[6]},  32'hB2);
    check("mem7",  {24'b0, mem[7]},  32'hA1);
    check("mem9",  {24'b0, mem[9]},  32'h80);
    check("mem30", {24'b0, mem[30]}, 32'h34);
    check("mem31", {24'b0, mem[31]}, 32'hF2);
    check("mem10", {24'b0, mem[10]}, 32'h5A);

    // Word store at 8 aborted by reset during its third access cycle.
    r0 = resp_cnt;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 5'd8;
    bus.req_wdata    = 32'h11223344;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready_after_rst", {31'b0, bus.req_ready}, 32'd1);
    check("abort_state_after_rst", {30'b0, fsm_state},     32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_resp", resp_cnt - r0, 0);
    check("abort_mem8",  {24'b0, mem[8]},  32'h44);
    check("abort_mem9",  {24'b0, mem[9]},  32'h33);
    check("abort_mem10", {24'b0, mem[10]}, 32'h5A);
    check("abort_mem11", {24'b0, mem[11]}, 32'h00);

    // req_valid held high for back-to-back word loads.
    accepts      = 0;
    viol         = 0;
    resp_in_loop = 0;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 5'd4;
    bus.req_wdata    = 32'h0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (bus.req_ready && bus.req_valid) begin
        if (accepts < 4) acc_idx[accepts] = i;
        accepts++;
      end
      if (fsm_state != 2'd0 && bus.req_ready) viol++;
      if (bus.resp_valid) begin
        resp_in_loop++;
        check("b2b_rdata", bus.resp_rdata, 32'hA1B2C3D4);
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b_accepts", accepts, 3);
    check("b2b_gap1", (accepts >= 2) ? acc_idx[1] - acc_idx[0] : -1, 6);
    check("b2b_gap2", (accepts >= 3) ? acc_idx[2] - acc_idx[1] : -1, 6);
    check("b2b_ready_low_when_busy", viol, 0);
    check("b2b_resps", resp_in_loop, 3);
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
